// File: rtl/store_checker.sv
// End-of-test responder on the CPU store bus: logs every store made while the test runs into a
// show-ahead FIFO, and decides pass, fail or timeout from the stores it sees.
module store_checker #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
  parameter int unsigned LOG_DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memwrite,
  input  logic [31:0]               dataadr,
  input  logic [31:0]               writedata,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [31:0]               rd_addr,
  output logic [31:0]               rd_data,
  output logic [LOG_DEPTH_LOG2:0]   log_count,
  output logic                      overflow,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timed_out
);

  localparam int unsigned                 DEPTH        = 2 ** LOG_DEPTH_LOG2;
  localparam logic [LOG_DEPTH_LOG2:0]     FULL_COUNT   = (LOG_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [LOG_DEPTH_LOG2:0]     CNT_ONE      = (LOG_DEPTH_LOG2 + 1)'(1);
  localparam logic [LOG_DEPTH_LOG2-1:0]   PTR_ONE      = (LOG_DEPTH_LOG2)'(1);
  localparam logic [31:0]                 TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit                          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]               cycle_count;
  logic [63:0]               log_mem [DEPTH];
  logic [LOG_DEPTH_LOG2-1:0] wr_ptr;
  logic [LOG_DEPTH_LOG2-1:0] rd_ptr;
  logic [63:0]               head;
  logic [31:0]               last_addr;
  logic [31:0]               last_data;

  logic in_run;
  logic push;
  logic pop;
  logic full;
  logic push_ok;

  assign in_run  = (state_q == S_RUN);
  assign push    = memwrite && in_run;
  assign pop     = rd_en && rd_valid;
  assign full    = (log_count == FULL_COUNT);
  // A full FIFO still takes the store when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);

  assign rd_valid = (log_count != '0);
  assign head     = log_mem[rd_ptr];
  assign rd_addr  = rd_valid ? head[63:32] : last_addr;
  assign rd_data  = rd_valid ? head[31:0]  : last_data;

  // Verdict FSM: state register plus registered verdict flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      done      <= (state_d != S_RUN);
      pass      <= (state_d == S_PASS);
      fail      <= (state_d == S_FAIL);
      timed_out <= (state_d == S_TIMEOUT);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN) begin
      if (memwrite) begin
        if (dataadr == PASS_ADDR) begin
          state_d = (writedata == PASS_DATA) ? S_PASS : S_FAIL;
        end else if (dataadr != SCRATCH_ADDR) begin
          state_d = S_FAIL;
        end
      end else if (TIMEOUT_EN && (cycle_count == TIMEOUT_LAST)) begin
        state_d = S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (in_run) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Log FIFO storage: data only, validity comes from log_count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      log_mem[wr_ptr] <= {dataadr, writedata};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_count <= '0;
      overflow  <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_addr <= head[63:32];
        last_data <= head[31:0];
      end
      case ({push_ok, pop})
        2'b10:   log_count <= log_count + CNT_ONE;
        2'b01:   log_count <= log_count - CNT_ONE;
        default: log_count <= log_count;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_checker.sv
// Scoreboard bench for store_checker: a queue-based reference model predicts log contents,
// occupancy and verdicts; a monitor checks every popped entry and every verdict event.
module tb_store_checker;

  localparam int TO_CYC = 20;
  localparam int DEPTH  = 8;
  localparam logic [2:0] V_PASS = 3'b100;
  localparam logic [2:0] V_FAIL = 3'b010;
  localparam logic [2:0] V_TO   = 3'b001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  log_count;
  logic        overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timed_out;

  store_checker #(
    .PASS_ADDR(32'd84), .PASS_DATA(32'd7), .SCRATCH_ADDR(32'd80),
    .LOG_DEPTH_LOG2(3), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_data(rd_data), .log_count(log_count), .overflow(overflow), .done(done),
    .pass(pass), .fail(fail), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [2:0]  m_verdict;
  int          m_cycles;
  int          m_cnt;
  bit          m_ovf;
  logic [63:0] exp_log[$];
  logic [2:0]  exp_verdict[$];
  bit          mon_prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic re);
    bit do_pop;
    logic [2:0] nv;
    do_pop = re && (m_cnt > 0);
    nv = m_verdict;
    if (m_verdict == 3'b000) begin
      if (we) begin
        if (m_cnt < DEPTH || do_pop) begin
          exp_log.push_back({a, d});
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
        if (a == 32'd84) nv = (d == 32'd7) ? V_PASS : V_FAIL;
        else if (a != 32'd80) nv = V_FAIL;
      end else if (m_cycles == TO_CYC - 1) begin
        nv = V_TO;
      end
      m_cycles++;
      if (nv != 3'b000) exp_verdict.push_back(nv);
    end
    if (do_pop) m_cnt--;
    m_verdict = nv;
  endtask

  // Called at posedge+2; returns at the following posedge+2
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic re);
    memwrite = we; dataadr = a; writedata = d; rd_en = re;
    model_step(we, a, d, re);
    @(posedge clk);
    #1;
    check("log_count", 64'(log_count), 64'(m_cnt));
    check("rd_valid", 64'(rd_valid), 64'(m_cnt != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("verdict_bits", 64'({done, pass, fail, timed_out}), 64'({|m_verdict, m_verdict}));
    #1;
  endtask

  task automatic do_reset();
    memwrite = 1'b0; rd_en = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_rd_addr", 64'(rd_addr), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_status", 64'({rd_valid, log_count, overflow, done, pass, fail, timed_out}), 64'd0);
    m_verdict = 3'b000; m_cycles = 0; m_cnt = 0; m_ovf = 1'b0;
    exp_log.delete();
    exp_verdict.delete();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && m_cnt > 0; k++) step(1'b0, 32'd0, 32'd0, 1'b1);
    check("log_drained", 64'(exp_log.size()), 64'd0);
  endtask

  // Monitor: a pop is committed when rd_en and rd_valid are both high ahead of the edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset && rd_en && rd_valid) begin
        if (exp_log.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL log_pop: got entry %0h/%0h, expected no entry", rd_addr, rd_data);
        end else begin
          check("log_entry", {rd_addr, rd_data}, exp_log.pop_front());
        end
      end
      if (done && !mon_prev_done) begin
        if (exp_verdict.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL verdict_event: got %b, expected no verdict", {pass, fail, timed_out});
        end else begin
          check("verdict_event", 64'({pass, fail, timed_out}), 64'(exp_verdict.pop_front()));
        end
      end
      mon_prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] d;
    int          r;
    #2;

    // Pass path
    do_reset();
    step(1'b1, 32'd80, 32'd3, 1'b0);
    step(1'b1, 32'd80, 32'd4, 1'b0);
    step(1'b1, 32'd84, 32'd7, 1'b0);
    check("pp_pass", 64'({done, pass, fail}), 64'(3'b110));
    check("pp_count", 64'(log_count), 64'd3);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // Wrong data, then a late store that must be ignored
    do_reset();
    step(1'b1, 32'd84, 32'd6, 1'b0);
    check("wd_fail", 64'({pass, fail}), 64'(2'b01));
    step(1'b1, 32'd84, 32'd7, 1'b0);
    check("wd_count", 64'(log_count), 64'd1);
    drain();

    // Stray address
    do_reset();
    step(1'b1, 32'd80, 32'd1, 1'b0);
    step(1'b1, 32'd96, 32'd9, 1'b0);
    check("sa_fail", 64'(fail), 64'd1);
    check("sa_count", 64'(log_count), 64'd2);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // Timeout on the 20th edge
    do_reset();
    for (int i = 0; i < TO_CYC - 1; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    check("to_early", 64'(timed_out), 64'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    check("to_fire", 64'({done, timed_out}), 64'(2'b11));
    step(1'b0, 32'd0, 32'd0, 1'b0);

    // A store on the timeout edge wins
    do_reset();
    for (int i = 0; i < TO_CYC - 1; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd84, 32'd7, 1'b0);
    check("to_store_wins", 64'({pass, timed_out}), 64'(2'b10));
    step(1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // Overflow with no reads
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'd80, 32'(i + 100), 1'b0);
    check("ov_count", 64'(log_count), 64'd8);
    check("ov_flag", 64'(overflow), 64'd1);
    drain();

    // Full FIFO with a same-cycle pop accepts the store
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'd80, 32'(i + 200), 1'b0);
    step(1'b1, 32'd80, 32'd208, 1'b1);
    check("fp_overflow", 64'(overflow), 64'd0);
    check("fp_count", 64'(log_count), 64'd8);
    drain();

    // Reset mid-run
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'd80, 32'(i), 1'b0);
    do_reset();
    step(1'b1, 32'd84, 32'd7, 1'b0);
    check("rm_pass", 64'(pass), 64'd1);
    check("rm_count", 64'(log_count), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // Randomized episodes
    for (int e = 0; e < 25; e++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        r  = $urandom_range(19, 0);
        we = 1'($urandom_range(1, 0));
        re = ($urandom_range(3, 0) == 0);
        if (r < 15) begin
          a = 32'd80;
          d = $urandom;
        end else if (r < 18) begin
          a = 32'd84;
          d = ($urandom_range(2, 0) == 0) ? 32'($urandom_range(15, 0)) : 32'd7;
        end else begin
          a = 32'h100 + 32'($urandom_range(63, 0)) * 32'd4;
          d = $urandom;
        end
        step(we, a, d, re);
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
